// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Instruction-fetch controller. Owns the program counter,
//               requests instruction words from memory, strobes the
//               instruction register, detects HALT and hands each
//               instruction to the execution unit via a valid/done handshake.
// Ports       : clock/reset      - clock, asynchronous active-high reset
//               start            - leave IDLE/HALT and begin fetching
//               memAddr/memRead  - fetch request to memory (addr = pc)
//               memReady         - memory word valid on the IR input bus
//               irNotLoad/irOE   - IR load strobe (active low), output enable
//               opcode           - opcode field from the IR output
//               instrValid       - instruction offered to the execution unit
//               execDone         - execution unit finished the instruction
//               branchTake/Target- PC redirect, sampled with execDone
//               pc / halted      - program counter, HALT indicator
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [6:0]  HALT_OPCODE = 7'h7F
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [15:0] memAddr,
    output logic        memRead,
    input  logic        memReady,
    output logic        irNotLoad,
    output logic        irOE,
    input  logic [6:0]  opcode,
    output logic        instrValid,
    input  logic        execDone,
    input  logic        branchTake,
    input  logic [15:0] branchTarget,
    output logic [15:0] pc,
    output logic        halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_ISSUE  = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;

    // State and PC registers; the asynchronous reset clears the state so all
    // Moore strobes drop immediately, independent of the clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    // Next-state and PC update. Inputs are only looked at in the state that
    // samples them, so stray strobes elsewhere have no effect.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (memReady) begin
                    w_pc_nxt    = r_pc + 16'd1;   // wraps modulo 2^16
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OPCODE) w_state_nxt = S_HALT;
                else                       w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (execDone) begin
                    if (branchTake) w_pc_nxt = branchTarget;
                    w_state_nxt = S_FETCH;
                end
            end
            S_HALT: begin
                if (start) w_state_nxt = S_FETCH;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from state. irNotLoad is the only Mealy output:
    // it pulses low in the single FETCH cycle where memReady is seen, and the
    // state leaves FETCH on that edge, so the IR loads once per fetch.
    assign memAddr    = r_pc;
    assign pc         = r_pc;
    assign memRead    = (r_state == S_FETCH);
    assign irNotLoad  = ~((r_state == S_FETCH) && memReady);
    assign irOE       = (r_state == S_DECODE) || (r_state == S_ISSUE) ||
                        (r_state == S_HALT);
    assign instrValid = (r_state == S_ISSUE);
    assign halted     = (r_state == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Self-checking bench for fetch_sequencer. A table of per-cycle
//               input/expected-output records is applied in a loop, expected
//               outputs going through a scoreboard queue; hand-written
//               sequences then cover asynchronous reset in FETCH and ISSUE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memReady;
    logic        irNotLoad;
    logic        irOE;
    logic [6:0]  opcode;
    logic        instrValid;
    logic        execDone;
    logic        branchTake;
    logic [15:0] branchTarget;
    logic [15:0] pc;
    logic        halted;

    fetch_sequencer #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (7'h7F)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .memAddr      (memAddr),
        .memRead      (memRead),
        .memReady     (memReady),
        .irNotLoad    (irNotLoad),
        .irOE         (irOE),
        .opcode       (opcode),
        .instrValid   (instrValid),
        .execDone     (execDone),
        .branchTake   (branchTake),
        .branchTarget (branchTarget),
        .pc           (pc),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        start;
        logic        rdy;
        logic [6:0]  op;
        logic        done;
        logic        bt;
        logic [15:0] tgt;
        logic        e_rd;
        logic [15:0] e_addr;
        logic        e_nl;
        logic        e_oe;
        logic        e_iv;
        logic        e_h;
    } vec_t;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic        nl;
        logic        oe;
        logic        iv;
        logic        h;
    } exp_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];
    exp_t sb [$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic r, input logic [6:0] o,
                         input logic d, input logic b, input logic [15:0] t);
        @(negedge clock);
        start        = s;
        memReady     = r;
        opcode       = o;
        execDone     = d;
        branchTake   = b;
        branchTarget = t;
    endtask

    initial begin
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0; memReady = 1'b0; opcode = 7'h00;
        execDone = 1'b0; branchTake = 1'b0; branchTarget = 16'h0000;

        //        start rdy op     done bt tgt       rd addr      nl oe iv h
        vecs[0]  = '{0, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0};
        vecs[1]  = '{1, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0, 0};
        vecs[2]  = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h0001, 1, 1, 0, 0};
        vecs[4]  = '{0, 0, 7'h00, 1, 0, 16'h0000, 0, 16'h0001, 1, 1, 1, 0};
        vecs[5]  = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'h0001, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h0002, 1, 1, 0, 0};
        vecs[7]  = '{0, 0, 7'h00, 1, 0, 16'h0000, 0, 16'h0002, 1, 1, 1, 0};
        // memory wait: two stall cycles, stray start/execDone ignored
        vecs[8]  = '{0, 0, 7'h00, 0, 0, 16'h0000, 1, 16'h0002, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 7'h00, 1, 1, 16'h0055, 1, 16'h0002, 1, 0, 0, 0};
        vecs[10] = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'h0002, 0, 0, 0, 0};
        // stray memReady in DECODE must not pulse irNotLoad
        vecs[11] = '{0, 1, 7'h00, 0, 0, 16'h0000, 0, 16'h0003, 1, 1, 0, 0};
        // branchTake without execDone: no effect
        vecs[12] = '{0, 0, 7'h00, 0, 1, 16'h1234, 0, 16'h0003, 1, 1, 1, 0};
        vecs[13] = '{0, 0, 7'h00, 1, 1, 16'h1234, 0, 16'h0003, 1, 1, 1, 0};
        vecs[14] = '{0, 0, 7'h00, 1, 1, 16'h0000, 1, 16'h1234, 1, 0, 0, 0};
        vecs[15] = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'h1234, 0, 0, 0, 0};
        // HALT word fetched from 16'h1234
        vecs[16] = '{0, 0, 7'h7F, 0, 0, 16'h0000, 0, 16'h1235, 1, 1, 0, 0};
        vecs[17] = '{0, 1, 7'h00, 0, 0, 16'h0000, 0, 16'h1235, 1, 1, 0, 1};
        vecs[18] = '{1, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h1235, 1, 1, 0, 1};
        vecs[19] = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'h1235, 0, 0, 0, 0};
        vecs[20] = '{0, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h1236, 1, 1, 0, 0};
        // branch to 16'hFFFF, then fetch wraps pc to 0
        vecs[21] = '{0, 0, 7'h00, 1, 1, 16'hFFFF, 0, 16'h1236, 1, 1, 1, 0};
        vecs[22] = '{0, 1, 7'h00, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 0};
        vecs[23] = '{0, 0, 7'h7F, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 0};
        vecs[24] = '{0, 0, 7'h00, 0, 0, 16'h0000, 0, 16'h0000, 1, 1, 0, 1};

        // Reset state while reset is held.
        @(negedge clock);
        @(negedge clock);
        chk("rst memRead", {15'd0, memRead}, 16'd0);
        chk("rst memAddr", memAddr, 16'h0000);
        chk("rst pc", pc, 16'h0000);
        chk("rst irNotLoad", {15'd0, irNotLoad}, 16'd1);
        chk("rst irOE", {15'd0, irOE}, 16'd0);
        chk("rst instrValid", {15'd0, instrValid}, 16'd0);
        chk("rst halted", {15'd0, halted}, 16'd0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].start, vecs[i].rdy, vecs[i].op,
                  vecs[i].done, vecs[i].bt, vecs[i].tgt);
            sb.push_back('{vecs[i].e_rd, vecs[i].e_addr, vecs[i].e_nl,
                           vecs[i].e_oe, vecs[i].e_iv, vecs[i].e_h});
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d memRead", i), {15'd0, memRead}, {15'd0, e.rd});
            chk($sformatf("v%0d memAddr", i), memAddr, e.addr);
            chk($sformatf("v%0d pc", i), pc, e.addr);
            chk($sformatf("v%0d irNotLoad", i), {15'd0, irNotLoad}, {15'd0, e.nl});
            chk($sformatf("v%0d irOE", i), {15'd0, irOE}, {15'd0, e.oe});
            chk($sformatf("v%0d instrValid", i), {15'd0, instrValid}, {15'd0, e.iv});
            chk($sformatf("v%0d halted", i), {15'd0, halted}, {15'd0, e.h});
        end

        // Reset mid-FETCH with pc = 1 and memReady arriving together.
        drive(1, 0, 7'h00, 0, 0, 16'h0000);   // HALT -> FETCH at pc 0
        drive(0, 1, 7'h00, 0, 0, 16'h0000);   // FETCH -> DECODE, pc 1
        drive(0, 0, 7'h00, 0, 0, 16'h0000);   // DECODE -> ISSUE
        drive(0, 0, 7'h00, 1, 0, 16'h0000);   // ISSUE -> FETCH
        drive(0, 1, 7'h00, 0, 0, 16'h0000);
        #1;
        chk("pre-rstF memRead", {15'd0, memRead}, 16'd1);
        chk("pre-rstF memAddr", memAddr, 16'h0001);
        reset = 1'b1;
        #1;
        chk("rstF memRead", {15'd0, memRead}, 16'd0);
        chk("rstF pc", pc, 16'h0000);
        chk("rstF irNotLoad", {15'd0, irNotLoad}, 16'd1);
        @(negedge clock);
        reset = 1'b0;                          // memReady still high
        #1;
        chk("postF memRead", {15'd0, memRead}, 16'd0);
        chk("postF irNotLoad", {15'd0, irNotLoad}, 16'd1);
        @(negedge clock);
        chk("postF2 pc", pc, 16'h0000);
        chk("postF2 irOE", {15'd0, irOE}, 16'd0);
        chk("postF2 memRead", {15'd0, memRead}, 16'd0);

        // Reset mid-ISSUE with a pending branching execDone.
        drive(1, 0, 7'h00, 0, 0, 16'h0000);   // IDLE -> FETCH
        drive(0, 1, 7'h00, 0, 0, 16'h0000);   // FETCH -> DECODE, pc 1
        drive(0, 0, 7'h00, 0, 0, 16'h0000);   // DECODE -> ISSUE
        drive(0, 0, 7'h00, 1, 1, 16'hABCD);
        #1;
        chk("pre-rstI instrValid", {15'd0, instrValid}, 16'd1);
        reset = 1'b1;
        #1;
        chk("rstI instrValid", {15'd0, instrValid}, 16'd0);
        chk("rstI pc", pc, 16'h0000);
        @(negedge clock);
        reset = 1'b0;                          // execDone/branchTake still high
        @(negedge clock);
        chk("postI pc", pc, 16'h0000);
        chk("postI instrValid", {15'd0, instrValid}, 16'd0);
        chk("postI memRead", {15'd0, memRead}, 16'd0);
        chk("postI halted", {15'd0, halted}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the CPU core. It owns the program counter, requests instruction words from memory, and strobes the instruction register to capture them. It checks the latched opcode for HALT, then hands each instruction to the execution unit through a valid/done handshake. It sits between the memory bus, the instruction register (active-low load, output enable) and the execution sequencer.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value after reset.
- `HALT_OPCODE`, 7'h7F, opcode that stops fetching.

Ports:
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  leave IDLE/HALT and begin fetching.
- `memAddr`  out  16  fetch address; equals `pc` while `memRead`=1.
- `memRead`  out  1  fetch request.
- `memReady`  in  1  memory data valid on the IR input bus this cycle.
- `irNotLoad`  out  1  active-low load strobe to the instruction register.
- `irOE`  out  1  instruction register output enable.
- `opcode`  in  7  opcode field from the instruction register output.
- `instrValid`  out  1  instruction available to the execution unit.
- `execDone`  in  1  execution unit finished the current instruction.
- `branchTake`  in  1  redirect the PC; sampled only with `execDone`.
- `branchTarget`  in  16  new PC when `branchTake`=1.
- `pc`  out  16  current program counter.
- `halted`  out  1  1 while in HALT.

## Operation
- State machine: IDLE, FETCH, DECODE, ISSUE, HALT.
- IDLE: all strobes are inactive. `start`=1 moves to FETCH. Otherwise the state stays IDLE.
- FETCH:
  - `memRead`=1 and `memAddr`=`pc`.
  - While `memReady`=0, the state stays FETCH.
  - With `memReady`=1, `irNotLoad`=0 combinationally in that same cycle. At the edge, the IR captures the word, `pc` <= `pc`+1, and the state moves to DECODE.
- DECODE:
  - `irOE`=1 for one cycle.
  - If `opcode`==`HALT_OPCODE`, the state moves to HALT. Otherwise it moves to ISSUE.
- ISSUE:
  - `irOE`=1 and `instrValid`=1.
  - While `execDone`=0, the state stays ISSUE.
  - With `execDone`=1: if `branchTake`=1, `pc` <= `branchTarget`; otherwise `pc` is unchanged. The state moves to FETCH.
- HALT: `halted`=1 and `irOE`=1. `start`=1 moves to FETCH, resuming at the `pc` after the halt word.
- PC arithmetic is 16-bit unsigned modulo 2^16: 16'hFFFF+1 = 16'h0000.
- Inputs outside their sampling state are ignored:
  - `memReady` outside FETCH.
  - `execDone` and `branchTake` outside ISSUE.
  - `start` outside IDLE/HALT.
- `irNotLoad` is 1 in every state except FETCH with `memReady`=1. The IR is never loaded twice for one fetch.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, `pc`=`RESET_PC`.
  - `memRead`=0, `irNotLoad`=1, `irOE`=0, `instrValid`=0, `halted`=0.
  - `memAddr`=`RESET_PC`.
- Reset during FETCH drops `memRead` immediately, without waiting for a clock edge. An in-flight `memReady` arriving after reset is ignored.
- Reset during ISSUE drops `instrValid` immediately. A pending `execDone` is ignored and `pc` is not updated.
- Minimum instruction period is 3 cycles (FETCH, DECODE, ISSUE), with `memReady` and `execDone` both high on their first cycle.
- Each memory wait cycle adds 1 cycle. Each execution wait cycle adds 1 cycle.
- `start` to first `memRead`: 1 cycle.
- Branch: the next `memAddr` equals `branchTarget` in the cycle after the `execDone` edge.
- All outputs are Moore outputs except `irNotLoad`, which also depends on `memReady`.

## Test plan
- Reset with `RESET_PC`=16'h0000, pulse `start`, zero-wait memory returning 16'h0000, immediate `execDone` -> `memAddr` sequence 0,1,2; `instrValid` every 3rd cycle; `irNotLoad`=0 exactly once per instruction.
- `memReady` delayed 2 cycles -> `memRead` held 3 cycles with `memAddr` stable; `pc` increments once; `irNotLoad` low only in the `memReady` cycle.
- `execDone` with `branchTake`=1 and `branchTarget`=16'h1234 -> next `memAddr`=16'h1234. Repeat with `branchTake`=1 while `execDone`=0 -> `pc` unchanged.
- Fetched word with opcode 7'h7F at address 5 -> `halted`=1 and `instrValid` stays 0; `start` -> fetch resumes at `memAddr`=6.
- `pc` at 16'hFFFF, successful fetch -> `pc`=16'h0000.
- Assert `reset` mid-FETCH and mid-ISSUE -> `memRead`/`instrValid` fall before the next edge; `pc`=`RESET_PC`; state IDLE; stray `memReady`/`execDone` afterwards have no effect.
